pc_counter: RTL and testbench

16-bit program counter for the Hack CPU datapath: a loadable, incrementable register built on the same load-enabled storage semantics as the single-bit cell. It sits directly downstream of the Bit/Register storage stage and feeds instruction ROM addressing. An optional 4-entry return-address stack supports call/return without CPU microcode.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_stack.sv | 70 +++++++
 rtl/pc_counter.sv | 97 +++++++++
 tb/tb_pc_counter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants and the next-PC select encoding for the program counter.
// No logic; the depth-width helper sizes the return-stack entry counter.
// Configuration macro PC_STACK_EN is consumed by pc_counter, not here.
package pc_pkg;

  localparam int PC_WIDTH       = 16;
  localparam int PC_STACK_DEPTH = 4;

  // Counter width able to hold 0..depth inclusive.
  function automatic int depth_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PC_DEPTH_W = depth_w(PC_STACK_DEPTH);

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_INC  = 3'd1,
    SEL_LOAD = 3'd2,
    SEL_CLR  = 3'd3,
    SEL_CALL = 3'd4,
    SEL_RET  = 3'd5
  } pc_sel_e;

endpackage

// File: rtl/pc_stack.sv
// Circular LIFO of return addresses with push/pop/flush, entry count and error pulse.
// Latency: push/pop take effect at the edge; top_dat is combinational from stored state only.
// No backpressure: overflow overwrites the oldest entry, underflow is ignored; both pulse err.
module pc_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_STACK_DEPTH,
  parameter int DW    = depth_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_dat,
  output logic [WIDTH-1:0] top_dat,
  output logic             empty,
  output logic [DW-1:0]    depth,
  output logic             err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [DW-1:0] CNT_ONE = DW'(1);
  localparam logic [DW-1:0] FULL    = DW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // ptr is the slot the next push writes; when full it points at the oldest entry.
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_m1;

  assign ptr_m1  = ptr - PTR_ONE;
  assign top_dat = mem[ptr_m1];
  assign empty   = (depth == '0);

  // Pointer, entry count and error pulse; flush and reset both empty the stack.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ptr   <= '0;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (pop) begin
        if (empty) begin
          err <= 1'b1;
        end else begin
          ptr   <= ptr_m1;
          depth <= depth - CNT_ONE;
        end
      end else if (push) begin
        ptr <= ptr + PTR_ONE;
        if (depth == FULL) begin
          err <= 1'b1;
        end else begin
          depth <= depth + CNT_ONE;
        end
      end
    end
  end

  // Entry storage; contents beyond depth are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && !pop && push) begin
      mem[ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/pc_counter.sv
// Hack program counter: priority mux of rst_n > clr > (ret > call) > load > inc > hold.
// Latency: controls sampled at posedge, out updated at that edge; no input-to-output comb path.
// No backpressure; return stack present only when macro PC_STACK_EN is defined.
module pc_counter
  import pc_pkg::*;
#(
  parameter int WIDTH       = PC_WIDTH,
  parameter int STACK_DEPTH = PC_STACK_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               in,
  input  logic                           load,
  input  logic                           inc,
  input  logic                           clr,
`ifdef PC_STACK_EN
  input  logic                           call,
  input  logic                           ret,
  output logic                           stk_err,
  output logic [$clog2(STACK_DEPTH):0]   stk_depth,
`endif
  output logic [WIDTH-1:0]               out
);

  localparam logic [WIDTH-1:0] PC_ONE = WIDTH'(1);

  pc_sel_e          sel;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] out_inc;

  assign out_inc = out + PC_ONE;

`ifdef PC_STACK_EN
  logic [WIDTH-1:0] top_dat;
  logic             stk_empty;

  pc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH),
    .DW    ($clog2(STACK_DEPTH) + 1)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (sel == SEL_CLR),
    .push     (sel == SEL_CALL),
    .pop      (sel == SEL_RET),
    .push_dat (out_inc),
    .top_dat  (top_dat),
    .empty    (stk_empty),
    .depth    (stk_depth),
    .err      (stk_err)
  );
`endif

  // Strict-priority select; lower-priority controls are dropped entirely.
  always_comb begin
    sel = SEL_HOLD;
    if (clr) begin
      sel = SEL_CLR;
`ifdef PC_STACK_EN
    end else if (ret) begin
      sel = SEL_RET;
    end else if (call) begin
      sel = SEL_CALL;
`endif
    end else if (load) begin
      sel = SEL_LOAD;
    end else if (inc) begin
      sel = SEL_INC;
    end
  end

  // Next-PC mux; an underflowing ret leaves the PC unchanged.
  always_comb begin
    out_nxt = out;
    case (sel)
      SEL_CLR:  out_nxt = '0;
      SEL_LOAD: out_nxt = in;
      SEL_INC:  out_nxt = out_inc;
`ifdef PC_STACK_EN
      SEL_CALL: out_nxt = in;
      SEL_RET:  out_nxt = stk_empty ? out : top_dat;
`endif
      default:  out_nxt = out;
    endcase
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_nxt;
    end
  end

endmodule

// File: tb/tb_pc_counter.sv
// Self-checking bench for pc_counter: directed scenarios plus random stimulus vs a queue model.
// Model updates at each posedge from the applied inputs; a compare process checks at negedge.
// Stack scenarios and checks are built only when PC_STACK_EN is defined.
module tb_pc_counter;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in;
  logic          load, inc, clr;
  logic [W-1:0]  out;
  logic          call, ret;
`ifdef PC_STACK_EN
  logic          stk_err;
  logic [DW-1:0] stk_depth;
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model: PC value, return stack as a queue (back = top), error flag.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  bit           m_err;

  pc_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .load      (load),
    .inc       (inc),
    .clr       (clr),
`ifdef PC_STACK_EN
    .call      (call),
    .ret       (ret),
    .stk_err   (stk_err),
    .stk_depth (stk_depth),
`endif
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_pc = '0;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (clr) begin
        m_pc = '0;
        m_stk.delete();
      end else if (STK && ret) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else m_pc = m_stk.pop_back();
      end else if (STK && call) begin
        m_stk.push_back(m_pc + 16'd1);
        if (m_stk.size() > DEPTH) begin
          void'(m_stk.pop_front());
          m_err = 1'b1;
        end
        m_pc = in;
      end else if (load) begin
        m_pc = in;
      end else if (inc) begin
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  // Hand-computed expectation checked against both the DUT and the model.
  task automatic expect_pc(input string name, input logic [W-1:0] exp);
    cmp({name, "_dut"}, 32'(out), 32'(exp));
    cmp({name, "_model"}, 32'(m_pc), 32'(exp));
  endtask

`ifdef PC_STACK_EN
  task automatic expect_stk(input string name, input logic e, input int d);
    cmp({name, "_err"}, 32'(stk_err), 32'(e));
    cmp({name, "_depth"}, 32'(stk_depth), 32'(d));
  endtask
`endif

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cyc_out", 32'(out), 32'(m_pc));
`ifdef PC_STACK_EN
      cmp("cyc_err", 32'(stk_err), 32'(m_err));
      cmp("cyc_depth", 32'(stk_depth), 32'(m_stk.size()));
`endif
    end
  end

  initial begin
    rst_n = 1'b0; in = 16'h1234; load = 1'b1; inc = 1'b0; clr = 1'b0;
    call = 1'b0; ret = 1'b0;
    m_pc = '0; m_err = 1'b0;

    // Reset beats a simultaneous load.
    tick();
    chk_en = 1'b1;
    expect_pc("reset", 16'h0000);
`ifdef PC_STACK_EN
    expect_stk("reset", 1'b0, 0);
`endif
    rst_n = 1'b1; load = 1'b0; inc = 1'b1;
    repeat (3) tick();
    expect_pc("inc3", 16'h0003);

    // Load over inc, then clr over both.
    load = 1'b1; in = 16'h00AA;
    tick();
    expect_pc("load_pri", 16'h00AA);
    clr = 1'b1;
    tick();
    expect_pc("clr_pri", 16'h0000);
    clr = 1'b0;

    // Wrap at 0xFFFF.
    inc = 1'b0; load = 1'b1; in = 16'hFFFE;
    tick();
    load = 1'b0; inc = 1'b1;
    tick();
    expect_pc("wrap_ffff", 16'hFFFF);
    tick();
    expect_pc("wrap_0000", 16'h0000);
    inc = 1'b0;

`ifdef PC_STACK_EN
    // Call/ret and underflow.
    load = 1'b1; in = 16'h0010;
    tick();
    load = 1'b0; call = 1'b1; in = 16'h0200;
    tick();
    expect_pc("call", 16'h0200);
    expect_stk("call", 1'b0, 1);
    call = 1'b0; ret = 1'b1;
    tick();
    expect_pc("ret", 16'h0011);
    expect_stk("ret", 1'b0, 0);
    tick();
    expect_pc("underflow", 16'h0011);
    expect_stk("underflow", 1'b1, 0);
    ret = 1'b0;
    tick();
    expect_stk("err_clear", 1'b0, 0);

    // Overflow: fifth call overwrites the oldest return address.
    clr = 1'b1;
    tick();
    clr = 1'b0; call = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in = W'(k * 16'h0100);
      tick();
    end
    expect_pc("ovf_pc", 16'h0500);
    expect_stk("ovf", 1'b1, 4);
    call = 1'b0; ret = 1'b1;
    tick();
    expect_pc("pop1", 16'h0401);
    expect_stk("pop1", 1'b0, 3);
    tick();
    expect_pc("pop2", 16'h0301);
    tick();
    expect_pc("pop3", 16'h0201);
    tick();
    expect_pc("pop4", 16'h0101);
    expect_stk("pop4", 1'b0, 0);
    ret = 1'b0;
`endif

    // Random stimulus; the compare process checks every cycle.
    for (int i = 0; i < 1000; i++) begin
      rst_n = ($urandom_range(31) != 0);
      clr   = ($urandom_range(15) == 0);
      load  = ($urandom_range(3) == 0);
      inc   = ($urandom_range(1) == 0);
      call  = STK && ($urandom_range(3) == 0);
      ret   = STK && ($urandom_range(3) == 0);
      in    = W'($urandom);
      if ($urandom_range(7) == 0) in = 16'hFFFF;
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
